pwm_decoder: RTL
================

// Module: pwm_decoder
// PURPOSE
//  Receive end of the team's 8-bit LED PWM encoding. Samples an asynchronous PWM pin,
//  measures each frame and recovers the 8-bit duty value `d` that produced it.
//  Also flags malformed frames and constant-level (0 / 255) inputs.
//  Sits between an input pin and any consumer of duty values, e.g. a loopback
//  check of the RGB PWM outputs or a host-driven LED level.
//  Encoding being decoded, one frame = FRAME clk cycles, frame starts on a rising edge:
//   - d=0: always low; d=255: always high.
//   - d=1..254: high for d+1 cycles, then low for the rest of the frame.
// PARAMETERS
//  FRAME    256  clk cycles per PWM frame; must equal the transmitter's counter modulus.
//  TIMEOUT  512  cycles with no edge before the input is declared constant; must be > FRAME.
// PORTS
//  clk        in   1  system clock; pwm_in is generated in the same clock domain or is slower.
//  rst        in   1  asynchronous, active-high reset.
//  pwm_in     in   1  PWM pin, asynchronous, not yet synchronised.
//  d          out  8  last decoded duty value; held until the next valid.
//  valid      out  1  1-cycle strobe: d has just been updated.
//  frame_err  out  1  1-cycle strobe: frame rejected (bad period or impossible high time).
//  stuck      out  1  level: input constant for >= TIMEOUT cycles; reset value 0.
// BEHAVIOUR
//  Reset (async assert, sync-released use): d=0, valid=0, frame_err=0, stuck=0,
//   sync flops=0, counters=0, state=IDLE.
//  Sync: s1<=pwm_in, s2<=s1, s3<=s2.
//   - rise = s2 & ~s3; fall = ~s2 & s3.
//   - Only s2 is used downstream.
//  Counters: width CW = $clog2(TIMEOUT)+1, all saturate at max, never wrap.
//   - per_cnt: cycles since last rise.
//   - hi_cnt: high cycles since last rise.
//   - idle_cnt: cycles since last rise or fall.
//   - On rise: per_cnt<=1, hi_cnt<=1. Otherwise per_cnt++ and hi_cnt += s2.
//   - Any edge: idle_cnt<=0; else idle_cnt++.
//  FSM:
//   - IDLE: no reference rise yet.
//     - rise -> LOCK, no output.
//     - idle_cnt==TIMEOUT-1 -> STUCK.
//   - LOCK: on rise, evaluate the old per_cnt/hi_cnt (values before the restart):
//     - per_cnt==FRAME and 2<=hi_cnt<=FRAME-1 -> d<=hi_cnt-1, valid=1. Stay LOCK.
//     - otherwise -> frame_err=1, d unchanged. Stay LOCK; this rise is the new reference.
//     - idle_cnt==TIMEOUT-1 -> STUCK.
//   - STUCK: on entry, and then every FRAME cycles while no edge arrives:
//     - d<=(s2 ? 8'd255 : 8'd0), valid=1, stuck=1.
//     - Use a frame-phase counter, reset on entry.
//     - rise -> LOCK, stuck<=0. This rise is the reference; no output on it.
//     - fall -> IDLE, stuck<=0.
//  Latency: for a rise first sampled by s1 at clk edge k, rise is detected in the cycle
//   after edge k+1, and valid/d/frame_err update at edge k+2. All outputs are registered.
//  Boundaries:
//   - hi_cnt==1 (1-cycle pulse) is not a legal code -> frame_err.
//   - hi_cnt==FRAME means no fall, so no rise either; it cannot occur.
//   - Period of FRAME±1 -> frame_err; no tolerance.
//   - Rise in the same cycle idle_cnt reaches TIMEOUT-1: the rise wins (LOCK/IDLE rules).
//   - Reset mid-frame: everything is cleared. The first rise after reset only arms LOCK,
//     so the first full frame after reset is reported one frame later.
//   - valid and frame_err are never high in the same cycle.
// STRUCTURE
//  Shared package/header (pwm_defs.vh):
//   - localparams FRAME_DEFAULT=256, DUTY_W=8.
//   - FSM codes ST_IDLE=2'd0, ST_LOCK=2'd1, ST_STUCK=2'd2.
//  Natural sub-module: sync_edge (2-FF synchroniser + s3 delay; outputs lvl, rise, fall).
//   Reusable for other pins.
//  Everything else stays in one always block plus the output registers.
// TESTING
//  Transmitter model d=128, FRAME=256, 4 frames:
//   - no output on the 1st rise;
//   - then valid with d=128 once per frame, exactly 256 cycles apart; frame_err never set.
//  Sweep d=1,2,127,253,254:
//   - each is decoded exactly (d=1 is a 2-cycle pulse -> d=1);
//   - valid lands at edge k+2 after the pin rise.
//  pwm_in held low 1000 cycles after reset:
//   - stuck=1 and valid with d=0 at idle 512;
//   - repeats at 768; then a rise -> stuck=0, next frame decoded normally.
//  pwm_in held high after locking on d=200: stuck=1, valid with d=255 after 512 idle cycles.
//  Period 255, then 257, with a 100-cycle high time: frame_err strobe each frame, d stays at its prior value.
//  Assert rst for 3 cycles mid-frame while locked on d=64:
//   - outputs clear immediately (asynchronously);
//   - the first valid after release comes at the 2nd rise, d=64.

Source files
------------

// File: rtl/pwm_decoder_pkg.sv
// Shared definitions for the PWM duty decoder: default frame/timeout sizes,
// duty width and FSM state encoding.
package pwm_decoder_pkg;

    localparam int FRAME_DEFAULT   = 256;
    localparam int TIMEOUT_DEFAULT = 512;
    localparam int DUTY_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_STUCK = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_decoder_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus one extra delay stage
// to produce single-cycle rise/fall pulses aligned with the synchronised level.
module pwm_decoder_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the 8-bit duty value from a PWM pin by timing the period and high
// time between consecutive rising edges; flags bad frames and constant input.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int FRAME   = FRAME_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] d,
    output logic              valid,
    output logic              frame_err,
    output logic              stuck
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int PW = $clog2(FRAME);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] FRAME_C  = CW'(FRAME);
    localparam logic [CW-1:0] HI_MIN   = CW'(2);
    localparam logic [CW-1:0] HI_MAX   = CW'(FRAME - 1);
    localparam logic [CW-1:0] IDLE_LIM = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(FRAME - 1);

    logic lvl, rise, fall;

    pwm_decoder_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_in),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    state_t            state, state_nxt;
    logic [CW-1:0]     per_cnt, hi_cnt, idle_cnt;
    logic [PW-1:0]     phase;
    logic [DUTY_W-1:0] d_nxt;
    logic              valid_nxt, err_nxt, stuck_nxt;

    // Counters saturate so a dead pin can never alias back into a legal frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            idle_cnt <= '0;
            phase    <= '0;
        end else begin
            if (rise) begin
                per_cnt <= CW'(1);
                hi_cnt  <= CW'(1);
            end else begin
                if (per_cnt != CNT_MAX)
                    per_cnt <= per_cnt + 1'b1;
                if (lvl && hi_cnt != CNT_MAX)
                    hi_cnt <= hi_cnt + 1'b1;
            end

            if (rise || fall)
                idle_cnt <= '0;
            else if (idle_cnt != CNT_MAX)
                idle_cnt <= idle_cnt + 1'b1;

            if (state != ST_STUCK || phase == PH_LAST)
                phase <= '0;
            else
                phase <= phase + 1'b1;
        end
    end

    logic frame_ok, to_stuck, ph_wrap;
    logic [DUTY_W-1:0] const_d;

    assign frame_ok = (per_cnt == FRAME_C) && (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);
    assign to_stuck = (idle_cnt == IDLE_LIM) && !rise && !fall;
    assign ph_wrap  = (phase == PH_LAST);
    assign const_d  = lvl ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (rise)          state_nxt = ST_LOCK;
                else if (to_stuck) state_nxt = ST_STUCK;
            end
            ST_LOCK: begin
                if (!rise && to_stuck) state_nxt = ST_STUCK;
            end
            ST_STUCK: begin
                if (rise)      state_nxt = ST_LOCK;
                else if (fall) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        d_nxt     = d;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        stuck_nxt = stuck;
        unique case (state)
            ST_IDLE: begin
                if (!rise && to_stuck) begin
                    d_nxt     = const_d;
                    valid_nxt = 1'b1;
                    stuck_nxt = 1'b1;
                end
            end
            ST_LOCK: begin
                if (rise) begin
                    if (frame_ok) begin
                        d_nxt     = DUTY_W'(hi_cnt - 1'b1);
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (to_stuck) begin
                    d_nxt     = const_d;
                    valid_nxt = 1'b1;
                    stuck_nxt = 1'b1;
                end
            end
            ST_STUCK: begin
                if (rise || fall) begin
                    stuck_nxt = 1'b0;
                end else if (ph_wrap) begin
                    d_nxt     = const_d;
                    valid_nxt = 1'b1;
                end
            end
            default: stuck_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d         <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            d         <= d_nxt;
            valid     <= valid_nxt;
            frame_err <= err_nxt;
            stuck     <= stuck_nxt;
        end
    end

endmodule
